irq1_mutex_arbiter: RTL and testbench

//  Arbiter for the IRQ1 mutex line in the ESPIC. It shares one external event source between node0 and node1.
//  On each ext_signal rising edge it grants the mutex IRQ to the higher-priority node and stretches the pulse.
//  The grant is then held until the owner releases it by opcode. Events that arrive while busy are queued.

---
 rtl/irq1_mutex_arbiter_if.sv | 23 ++
 rtl/irq1_mutex_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_irq1_mutex_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/irq1_mutex_arbiter_if.sv
// Event, opcode and grant/status bundle between the IRQ1 mutex arbiter and its two nodes.
// The arbiter uses the slave modport; the node side (or a bench) uses master.
interface irq1_mutex_arbiter_if;
  logic        ext_signal;
  logic [15:0] in_op_node0;
  logic [15:0] in_op_node1;
  logic [1:0]  out_mutex_IRQ1;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  pending_cnt;
  logic        drop_flag;
  logic        timeout_flag;

  modport master (
    output ext_signal, in_op_node0, in_op_node1,
    input  out_mutex_IRQ1, owner, busy, pending_cnt, drop_flag, timeout_flag
  );

  modport slave (
    input  ext_signal, in_op_node0, in_op_node1,
    output out_mutex_IRQ1, owner, busy, pending_cnt, drop_flag, timeout_flag
  );
endinterface

// File: rtl/irq1_mutex_arbiter.sv
// IRQ1 mutex arbiter: shares one external event between node0/node1 by priority with round-robin ties.
// Optional forced release of a stuck HOLD is enabled with `define IRQ_TIMEOUT_EN.
module irq1_mutex_arbiter #(
  parameter int unsigned PULSE_LEN = 1000,
  parameter int unsigned TIMEOUT   = 100000,
  parameter logic [3:0]  PRIO0_RST = 4'd2,
  parameter logic [3:0]  PRIO1_RST = 4'd4
) (
  input logic                 CLK,
  input logic                 RST,
  irq1_mutex_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W      = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Higher priority wins; on a tie the node that did not win last time gets it.
  function automatic logic [1:0] arb_pick(input logic [3:0] p0, input logic [3:0] p1, input logic rr_last);
    logic [1:0] pick;
    if (p0 > p1) begin
      pick = 2'b01;
    end else if (p1 > p0) begin
      pick = 2'b10;
    end else if (rr_last) begin
      pick = 2'b01;
    end else begin
      pick = 2'b10;
    end
    return pick;
  endfunction

  logic             s1_r, s2_r, s3_r;
  logic [15:0]      op0_q_r, op1_q_r;
  logic [3:0]       prio0_r, prio1_r;
  logic             rr_last_r, rr_last_nx;
  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [1:0]       irq_r, irq_nx;
  logic [1:0]       owner_r, owner_nx;
  logic             busy_r;
  logic [3:0]       pending_r, pending_nx;
  logic             drop_r, drop_nx;

  logic       edge_s;
  logic       cmd0_s, cmd1_s;
  logic       set0_s, set1_s;
  logic       rel0_s, rel1_s;
  logic       rel_owner_s;
  logic [1:0] win_s;
  logic       take_edge_s, take_pend_s, inc_s;

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned      HOLD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
  logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nx;
  logic              timeout_r, timeout_nx;
`endif

  assign edge_s      = s2_r & ~s3_r;
  assign cmd0_s      = (bus.in_op_node0 != op0_q_r);
  assign cmd1_s      = (bus.in_op_node1 != op1_q_r);
  assign set0_s      = cmd0_s && ((bus.in_op_node0 & 16'h3FF0) == 16'h2F10);
  assign set1_s      = cmd1_s && ((bus.in_op_node1 & 16'h3FF0) == 16'h2F10);
  assign rel0_s      = cmd0_s && (bus.in_op_node0 == 16'h3F20);
  assign rel1_s      = cmd1_s && (bus.in_op_node1 == 16'h3F20);
  assign rel_owner_s = ((owner_r == 2'b01) && rel0_s) || ((owner_r == 2'b10) && rel1_s);
  assign win_s       = arb_pick(prio0_r, prio1_r, rr_last_r);

  // Event synchroniser, opcode history and per-node priority registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      s3_r    <= 1'b0;
      op0_q_r <= 16'h0000;
      op1_q_r <= 16'h0000;
      prio0_r <= PRIO0_RST;
      prio1_r <= PRIO1_RST;
    end else begin
      s1_r    <= bus.ext_signal;
      s2_r    <= s1_r;
      s3_r    <= s2_r;
      op0_q_r <= bus.in_op_node0;
      op1_q_r <= bus.in_op_node1;
      if (set0_s) prio0_r <= bus.in_op_node0[3:0];
      if (set1_s) prio1_r <= bus.in_op_node1[3:0];
    end
  end

  // Next-state, grant outputs and event-queue bookkeeping.
  always_comb begin
    state_nx    = state_r;
    cnt_nx      = cnt_r;
    irq_nx      = irq_r;
    owner_nx    = owner_r;
    rr_last_nx  = rr_last_r;
    take_edge_s = 1'b0;
    take_pend_s = 1'b0;
`ifdef IRQ_TIMEOUT_EN
    hold_cnt_nx = hold_cnt_r;
    timeout_nx  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (edge_s || (pending_r != 4'd0)) begin
          state_nx   = ST_GRANT;
          owner_nx   = win_s;
          irq_nx     = win_s;
          cnt_nx     = '0;
          rr_last_nx = win_s[1];
          if (edge_s) begin
            take_edge_s = 1'b1;
          end else begin
            take_pend_s = 1'b1;
          end
        end else begin
          owner_nx = 2'b00;
          irq_nx   = 2'b00;
        end
      end
      ST_GRANT: begin
        if (rel_owner_s) begin
          state_nx = ST_IDLE;
          owner_nx = 2'b00;
          irq_nx   = 2'b00;
        end else if (cnt_r == PULSE_LAST) begin
          state_nx = ST_HOLD;
          irq_nx   = 2'b00;
`ifdef IRQ_TIMEOUT_EN
          hold_cnt_nx = '0;
`endif
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        irq_nx = 2'b00;
        if (rel_owner_s) begin
          state_nx = ST_IDLE;
          owner_nx = 2'b00;
`ifdef IRQ_TIMEOUT_EN
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_nx   = ST_IDLE;
          owner_nx   = 2'b00;
          timeout_nx = 1'b1;
        end else begin
          hold_cnt_nx = hold_cnt_r + HOLD_W'(1);
        end
`else
        end else begin
          owner_nx = owner_r;
        end
`endif
      end
      default: begin
        state_nx = ST_IDLE;
        owner_nx = 2'b00;
        irq_nx   = 2'b00;
      end
    endcase

    // Edges not consumed by an IDLE grant are queued; the queue saturates at 15.
    inc_s      = edge_s & ~take_edge_s;
    pending_nx = pending_r;
    drop_nx    = drop_r;
    if (inc_s && !take_pend_s) begin
      if (pending_r == 4'd15) begin
        drop_nx = 1'b1;
      end else begin
        pending_nx = pending_r + 4'd1;
      end
    end else if (take_pend_s && !inc_s) begin
      pending_nx = pending_r - 4'd1;
    end else begin
      pending_nx = pending_r;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      irq_r     <= 2'b00;
      owner_r   <= 2'b00;
      busy_r    <= 1'b0;
      rr_last_r <= 1'b1;
      pending_r <= 4'd0;
      drop_r    <= 1'b0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      irq_r     <= irq_nx;
      owner_r   <= owner_nx;
      busy_r    <= (state_nx != ST_IDLE);
      rr_last_r <= rr_last_nx;
      pending_r <= pending_nx;
      drop_r    <= drop_nx;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  // HOLD watchdog counter and its one-cycle release pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      hold_cnt_r <= hold_cnt_nx;
      timeout_r  <= timeout_nx;
    end
  end

  assign bus.timeout_flag = timeout_r;
`else
  assign bus.timeout_flag = 1'b0;
`endif

  assign bus.out_mutex_IRQ1 = irq_r;
  assign bus.owner          = owner_r;
  assign bus.busy           = busy_r;
  assign bus.pending_cnt    = pending_r;
  assign bus.drop_flag      = drop_r;

endmodule

// File: tb/tb_irq1_mutex_arbiter.sv
// Directed self-checking bench for irq1_mutex_arbiter (PULSE_LEN=16, TIMEOUT=50).
module tb_irq1_mutex_arbiter;
  localparam int unsigned PULSE_LEN = 16;
  localparam int unsigned TIMEOUT   = 50;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  irq1_mutex_arbiter_if bus();

  irq1_mutex_arbiter #(
    .PULSE_LEN(PULSE_LEN), .TIMEOUT(TIMEOUT), .PRIO0_RST(4'd2), .PRIO1_RST(4'd4)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.ext_signal  = 1'b0;
    bus.in_op_node0 = 16'h0000;
    bus.in_op_node1 = 16'h0000;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  // One-cycle pulse on ext_signal; returns one cycle after it was sampled.
  task automatic send_event();
    bus.ext_signal = 1'b1;
    tick(1);
    bus.ext_signal = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.ext_signal  = 1'b0;
    bus.in_op_node0 = 16'h0000;
    bus.in_op_node1 = 16'h0000;
    tick(2);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00) begin errors++; $display("FAIL reset_irq got %b want 00", bus.out_mutex_IRQ1); end
    checks++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b want 00", bus.owner); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.pending_cnt !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", bus.pending_cnt); end
    checks++; if (bus.drop_flag !== 1'b0 || bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", bus.drop_flag, bus.timeout_flag); end
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_grant();
    int hi;
    do_reset();
    send_event();
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00) begin errors++; $display("FAIL latency_k1 got %b want 00", bus.out_mutex_IRQ1); end
    tick(1);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b10) begin errors++; $display("FAIL latency_k2 got %b want 10", bus.out_mutex_IRQ1); end
    checks++; if (bus.owner !== 2'b10 || bus.busy !== 1'b1) begin errors++; $display("FAIL grant_owner got %b/%b want 10/1", bus.owner, bus.busy); end
    hi = 1;
    for (int i = 1; i < int'(PULSE_LEN); i++) begin
      tick(1);
      if (bus.out_mutex_IRQ1 === 2'b10) hi++;
    end
    tick(1);
    checks++; if (hi !== int'(PULSE_LEN)) begin errors++; $display("FAIL pulse_width got %0d want %0d", hi, PULSE_LEN); end
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00 || bus.owner !== 2'b10 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL hold_state got irq=%b owner=%b busy=%b want 00/10/1", bus.out_mutex_IRQ1, bus.owner, bus.busy);
    end
    bus.in_op_node1 = 16'h3F20;
    tick(1);
    checks++; if (bus.owner !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL release got %b/%b want 00/0", bus.owner, bus.busy); end
    bus.in_op_node1 = 16'h0000;
    tick(1);
  endtask

  task automatic test_setprio();
    do_reset();
    bus.in_op_node0 = 16'h2F17;
    bus.in_op_node1 = 16'h2F13;
    tick(1);
    send_event();
    tick(1);
    checks++; if (bus.owner !== 2'b01 || bus.out_mutex_IRQ1 !== 2'b01) begin errors++; $display("FAIL prio_grant got %b/%b want 01/01", bus.owner, bus.out_mutex_IRQ1); end
    tick(PULSE_LEN);
    bus.in_op_node1 = 16'h3F20;
    tick(1);
    checks++; if (bus.owner !== 2'b01 || bus.busy !== 1'b1 || bus.out_mutex_IRQ1 !== 2'b00) begin
      errors++; $display("FAIL nonowner_release got owner=%b busy=%b irq=%b want 01/1/00", bus.owner, bus.busy, bus.out_mutex_IRQ1);
    end
    bus.in_op_node0 = 16'h3F20;
    tick(1);
    checks++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL owner_release got %b want 00", bus.owner); end
    bus.in_op_node0 = 16'h0000;
    bus.in_op_node1 = 16'h0000;
    tick(1);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_owner [4];
    exp_owner = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    bus.in_op_node0 = 16'h2F15;
    bus.in_op_node1 = 16'h2F15;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      send_event();
      tick(1);
      checks++; if (bus.owner !== exp_owner[i]) begin errors++; $display("FAIL rr_grant%0d got %b want %b", i, bus.owner, exp_owner[i]); end
      if (exp_owner[i] == 2'b01) bus.in_op_node0 = 16'h3F20;
      else bus.in_op_node1 = 16'h3F20;
      tick(1);
      checks++; if (bus.owner !== 2'b00) begin errors++; $display("FAIL rr_release%0d got %b want 00", i, bus.owner); end
      bus.in_op_node0 = 16'h0000;
      bus.in_op_node1 = 16'h0000;
      tick(1);
    end
  endtask

  task automatic test_queue();
    do_reset();
    send_event();
    tick(1);
    tick(PULSE_LEN);
    for (int i = 0; i < 17; i++) send_event();
    tick(2);
    checks++; if (bus.pending_cnt !== 4'd15) begin errors++; $display("FAIL queue_sat got %0d want 15", bus.pending_cnt); end
    checks++; if (bus.drop_flag !== 1'b1) begin errors++; $display("FAIL queue_drop got %b want 1", bus.drop_flag); end
    for (int i = 0; i < 15; i++) begin
      bus.in_op_node1 = 16'h3F20;
      tick(1);
      checks++; if (bus.owner !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL queue_idle%0d got %b/%b want 00/0", i, bus.owner, bus.busy); end
      bus.in_op_node1 = 16'h0000;
      tick(1);
      checks++; if (bus.owner !== 2'b10 || bus.pending_cnt !== 4'(14 - i)) begin
        errors++; $display("FAIL queue_regrant%0d got owner=%b pending=%0d want 10/%0d", i, bus.owner, bus.pending_cnt, 14 - i);
      end
    end
    bus.in_op_node1 = 16'h3F20;
    tick(1);
    bus.in_op_node1 = 16'h0000;
    tick(2);
    checks++; if (bus.owner !== 2'b00 || bus.busy !== 1'b0 || bus.pending_cnt !== 4'd0 || bus.drop_flag !== 1'b1) begin
      errors++; $display("FAIL queue_empty got owner=%b busy=%b pending=%0d drop=%b want 00/0/0/1", bus.owner, bus.busy, bus.pending_cnt, bus.drop_flag);
    end
  endtask

  task automatic test_early_release_and_reset();
    do_reset();
    send_event();
    tick(1);
    tick(9);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b10) begin errors++; $display("FAIL early_pre got %b want 10", bus.out_mutex_IRQ1); end
    bus.in_op_node1 = 16'h3F20;
    tick(1);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00 || bus.owner !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL early_release got irq=%b owner=%b busy=%b want 00/00/0", bus.out_mutex_IRQ1, bus.owner, bus.busy);
    end
    bus.in_op_node1 = 16'h0000;
    tick(1);
    send_event();
    tick(1);
    tick(PULSE_LEN);
    send_event();
    tick(1);
    checks++; if (bus.pending_cnt !== 4'd1 || bus.owner !== 2'b10) begin errors++; $display("FAIL pre_reset got pending=%0d owner=%b want 1/10", bus.pending_cnt, bus.owner); end
    RST = 1'b1;
    tick(1);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00 || bus.owner !== 2'b00 || bus.busy !== 1'b0 || bus.pending_cnt !== 4'd0) begin
      errors++; $display("FAIL hold_reset got irq=%b owner=%b busy=%b pending=%0d want all 0", bus.out_mutex_IRQ1, bus.owner, bus.busy, bus.pending_cnt);
    end
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_hold_timeout();
    do_reset();
    send_event();
    tick(1);
    tick(PULSE_LEN);
    checks++; if (bus.out_mutex_IRQ1 !== 2'b00 || bus.owner !== 2'b10) begin errors++; $display("FAIL to_hold got %b/%b want 00/10", bus.out_mutex_IRQ1, bus.owner); end
`ifdef IRQ_TIMEOUT_EN
    tick(TIMEOUT - 1);
    checks++; if (bus.owner !== 2'b10 || bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL to_before got %b/%b want 10/0", bus.owner, bus.timeout_flag); end
    tick(1);
    checks++; if (bus.owner !== 2'b00 || bus.timeout_flag !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_fire got owner=%b flag=%b busy=%b want 00/1/0", bus.owner, bus.timeout_flag, bus.busy);
    end
    tick(1);
    checks++; if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL to_pulse got %b want 0", bus.timeout_flag); end
`else
    tick(TIMEOUT + 10);
    checks++; if (bus.owner !== 2'b10 || bus.busy !== 1'b1 || bus.timeout_flag !== 1'b0) begin
      errors++; $display("FAIL hold_persist got owner=%b busy=%b flag=%b want 10/1/0", bus.owner, bus.busy, bus.timeout_flag);
    end
`endif
  endtask

  initial begin
    bus.ext_signal  = 1'b0;
    bus.in_op_node0 = 16'h0000;
    bus.in_op_node1 = 16'h0000;
    test_reset();
    test_basic_grant();
    test_setprio();
    test_round_robin();
    test_queue();
    test_early_release_and_reset();
    test_hold_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
